// File: rtl/pwm_pkg.sv
// Shared types and default parameter values for the breathing PWM block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   mode_t - per-channel operating mode (fixed duty or triangle sweep)
//   dir_t  - sweep direction
//   PWM_DEF_* - default values for the pwm_breathe_mc parameters
package pwm_pkg;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_SWEEP  = 1'b1
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int unsigned PWM_DEF_N_CH       = 4;
    localparam int unsigned PWM_DEF_CW         = 8;
    localparam int unsigned PWM_DEF_PERIOD     = 100;
    localparam int unsigned PWM_DEF_STEP       = 5;
    localparam int unsigned PWM_DEF_SWEEP_DIV  = 1;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty and mode, sweep direction, compare flop.
// Latency: pwm_o is registered, one clock after the counter value it compares.
// Backpressure: none; writes are always accepted into the shadow register.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   en_i            - run enable; while low the shadow is copied every clock
//   cnt_i           - shared period counter
//   boundary_i      - last clock of the current period
//   sweep_tick_i    - boundary on which SWEEP channels take a step
//   period_i        - active period (value before any boundary update)
//   wr_i            - decoded write strobe for this channel
//   wr_duty_i       - duty to place in the shadow register
//   wr_mode_i       - mode to place in the shadow register
//   pwm_o           - registered PWM output
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned CW   = PWM_DEF_CW,
    parameter int unsigned STEP = PWM_DEF_STEP
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
    input  logic [CW-1:0] cnt_i,
    input  logic          boundary_i,
    input  logic          sweep_tick_i,
    input  logic [CW-1:0] period_i,
    input  logic          wr_i,
    input  logic [CW-1:0] wr_duty_i,
    input  mode_t         wr_mode_i,
    output logic          pwm_o
);

    // Step size held one bit wider than the duty so the ramp arithmetic
    // can detect overshoot instead of wrapping.
    localparam logic [CW:0] STEP_X = (CW+1)'(STEP);

    logic [CW-1:0] shadow_duty_q, shadow_duty_d;
    mode_t         shadow_mode_q, shadow_mode_d;
    logic          pending_q,     pending_d;
    logic [CW-1:0] duty_q,        duty_d;
    mode_t         mode_q,        mode_d;
    dir_t          dir_q,         dir_d;
    logic          pwm_q,         pwm_d;

    logic          transfer;
    logic [CW:0]   up_sum;
    logic [CW:0]   duty_x;
    logic [CW:0]   period_x;

    always_comb begin
        shadow_duty_d = shadow_duty_q;
        shadow_mode_d = shadow_mode_q;
        pending_d     = pending_q;
        duty_d        = duty_q;
        mode_d        = mode_q;
        dir_d         = dir_q;

        duty_x   = {1'b0, duty_q};
        period_x = {1'b0, period_i};
        up_sum   = duty_x + STEP_X;

        // Shadow moves to active only at a period edge (or freely while
        // stopped) so a running period never sees its duty change.
        transfer = pending_q && (boundary_i || !en_i);

        // A write in the same clock as a transfer re-arms pending: the new
        // value waits for the next edge rather than being lost.
        if (wr_i) begin
            shadow_duty_d = wr_duty_i;
            shadow_mode_d = wr_mode_i;
            pending_d     = 1'b1;
        end else if (transfer) begin
            pending_d = 1'b0;
        end

        if (transfer) begin
            duty_d = shadow_duty_q;
            mode_d = shadow_mode_q;
            dir_d  = DIR_UP;
        end else if (sweep_tick_i && (mode_q == MODE_SWEEP)) begin
            if (dir_q == DIR_UP) begin
                // Clamp at the period top and turn around.
                if (up_sum >= period_x) begin
                    duty_d = period_i;
                    dir_d  = DIR_DOWN;
                end else begin
                    duty_d = up_sum[CW-1:0];
                end
            end else begin
                // Clamp at zero and turn around.
                if (duty_x <= STEP_X) begin
                    duty_d = '0;
                    dir_d  = DIR_UP;
                end else begin
                    duty_d = duty_q - STEP_X[CW-1:0];
                end
            end
        end

        pwm_d = en_i && (cnt_i < duty_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_duty_q <= '0;
            shadow_mode_q <= MODE_STATIC;
            pending_q     <= 1'b0;
            duty_q        <= '0;
            mode_q        <= MODE_STATIC;
            dir_q         <= DIR_UP;
            pwm_q         <= 1'b0;
        end else begin
            shadow_duty_q <= shadow_duty_d;
            shadow_mode_q <= shadow_mode_d;
            pending_q     <= pending_d;
            duty_q        <= duty_d;
            mode_q        <= mode_d;
            dir_q         <= dir_d;
            pwm_q         <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_breathe_mc.sv
// Multi-channel PWM with shared period counter, per-channel STATIC/SWEEP duty.
// Latency: pwm_out and cyc_start are registered, one clock behind the counter.
// Backpressure: none; config writes are always accepted and double-buffered.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   en          - run enable; low holds counter, divider and outputs at 0
//   period      - requested period in clocks, taken at a period edge (0 -> 1)
//   wr_en       - config write strobe
//   wr_ch       - target channel (values >= N_CH are ignored)
//   wr_duty     - duty in high clocks per period
//   wr_mode     - 0 = STATIC, 1 = SWEEP
//   pwm_out     - one registered PWM output per channel
//   cyc_start   - high in the first clock of each period
module pwm_breathe_mc
    import pwm_pkg::*;
#(
    parameter int unsigned N_CH       = PWM_DEF_N_CH,
    parameter int unsigned CW         = PWM_DEF_CW,
    parameter int unsigned DEF_PERIOD = PWM_DEF_PERIOD,
    parameter int unsigned STEP       = PWM_DEF_STEP,
    parameter int unsigned SWEEP_DIV  = PWM_DEF_SWEEP_DIV,
    localparam int unsigned CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [CW-1:0]   period,
    input  logic            wr_en,
    input  logic [CHW-1:0]  wr_ch,
    input  logic [CW-1:0]   wr_duty,
    input  logic            wr_mode,
    output logic [N_CH-1:0] pwm_out,
    output logic            cyc_start
);

    localparam int unsigned DW = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SWEEP_DIV - 1);

    logic [CW-1:0] cnt_q,           cnt_d;
    logic [CW-1:0] period_active_q, period_active_d;
    logic [DW-1:0] divcnt_q,        divcnt_d;
    logic          cyc_start_q;

    logic          boundary;
    logic          sweep_tick;

    always_comb begin
        // period_active is never 0, so the subtraction cannot underflow.
        boundary   = en && (cnt_q == (period_active_q - CW'(1)));
        sweep_tick = boundary && (divcnt_q == DIV_LAST);

        cnt_d           = cnt_q;
        period_active_d = period_active_q;
        divcnt_d        = divcnt_q;

        if (!en) begin
            cnt_d    = '0;
            divcnt_d = '0;
        end else if (boundary) begin
            cnt_d           = '0;
            period_active_d = (period == '0) ? CW'(1) : period;
            divcnt_d        = sweep_tick ? '0 : (divcnt_q + DW'(1));
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q           <= '0;
            period_active_q <= CW'(DEF_PERIOD);
            divcnt_q        <= '0;
            cyc_start_q     <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            period_active_q <= period_active_d;
            divcnt_q        <= divcnt_d;
            // Registered from the last clock of a period, so it lines up
            // with cnt==0 of the next one.
            cyc_start_q     <= boundary;
        end
    end

    assign cyc_start = cyc_start_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        // Out-of-range channel numbers never match any instance.
        logic wr_sel;
        assign wr_sel = wr_en && (wr_ch == CHW'(c));

        pwm_channel #(
            .CW   (CW),
            .STEP (STEP)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .en_i         (en),
            .cnt_i        (cnt_q),
            .boundary_i   (boundary),
            .sweep_tick_i (sweep_tick),
            .period_i     (period_active_q),
            .wr_i         (wr_sel),
            .wr_duty_i    (wr_duty),
            .wr_mode_i    (mode_t'(wr_mode)),
            .pwm_o        (pwm_out[c])
        );
    end

endmodule
